// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and types for the instruction fetch controller.
package fetch_ctrl_pkg;

   // Instruction word width and opcode field layout (opcode in the top bits).
   localparam int WIDTH   = 32;
   localparam int OP_BITS = 6;

   // Opcode values understood by the fetch stage.
   localparam logic [OP_BITS-1:0] OP_NOP  = 6'h00;
   localparam logic [OP_BITS-1:0] OP_ADD  = 6'h01;
   localparam logic [OP_BITS-1:0] OP_BR   = 6'h04;
   localparam logic [OP_BITS-1:0] OP_HALT = 6'h3F;

   // Fetch controller states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_t;

   // True when the opcode field of an instruction word is HALT.
   function automatic logic is_halt(input logic [WIDTH-1:0] word);
      return word[WIDTH-1 -: OP_BITS] == OP_HALT;
   endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: instruction memory port, decode handshake and
// branch redirect from execute.
interface fetch_ctrl_if;
   import fetch_ctrl_pkg::*;

   logic             start;
   logic [31:0]      pc;
   logic [WIDTH-1:0] inst;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_inst;
   logic [31:0]      out_pc;
   logic             redirect;
   logic [31:0]      redirect_pc;
   logic             halted;

   // Fetch controller side.
   modport master (
      input  start, inst, out_ready, redirect, redirect_pc,
      output pc, out_valid, out_inst, out_pc, halted
   );

   // Environment side (instruction memory, decode, execute).
   modport slave (
      output start, inst, out_ready, redirect, redirect_pc,
      input  pc, out_valid, out_inst, out_pc, halted
   );
endinterface

// File: rtl/fetch_fifo.sv
// Small fetch buffer: power-of-two depth, combinational head read,
// push/pop/flush with full/empty flags.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int DW    = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] push_data,
   output logic [DW-1:0] head_data,
   output logic          full,
   output logic          empty
);
   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [AW:0]   wr_ptr_reg;
   logic [AW:0]   rd_ptr_reg;
   logic [DW-1:0] mem_reg [DEPTH];
   logic          do_push;
   logic          do_pop;

   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign head_data = mem_reg[rd_ptr_reg[AW-1:0]];

   // Pointer update; flush empties the buffer regardless of push/pop.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
      end
   end

   // Per-entry storage write; contents are only meaningful while counted.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
         if (do_push && (wr_ptr_reg[AW-1:0] == AW'(gi)))
            mem_reg[gi] <= push_data;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks pc through memory, buffers
// {pc, inst} pairs for decode, stops on HALT and follows branch redirects.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] BOOT_PC    = 32'd0,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic   clk,
   input  logic   rst_n,
   fetch_ctrl_if.master bus
);
   localparam int DW = 32 + WIDTH;

   fetch_state_t  state_reg, state_next;
   logic [31:0]   pc_reg, pc_next;
   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_flush;
   logic          fifo_full;
   logic          fifo_empty;
   logic [DW-1:0] fifo_head;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (DW)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (fifo_flush),
      .push      (fifo_push),
      .pop       (fifo_pop),
      .push_data ({pc_reg, bus.inst}),
      .head_data (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // A transfer to decode happens whenever the head is valid and accepted.
   assign fifo_pop = !fifo_empty && bus.out_ready;

   // Outputs read as zero while the buffer is empty so reset clears them.
   assign bus.out_valid = !fifo_empty;
   assign bus.out_inst  = fifo_empty ? '0 : fifo_head[WIDTH-1:0];
   assign bus.out_pc    = fifo_empty ? '0 : fifo_head[DW-1:WIDTH];
   assign bus.pc        = pc_reg;
   assign bus.halted    = (state_reg == ST_HALTED);

   // State and pc registers; pc is always a flop so out_ready/redirect
   // never reach it combinationally.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         pc_reg    <= BOOT_PC;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
      end
   end

   // Next-state, next-pc and buffer control.
   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      fifo_push  = 1'b0;
      fifo_flush = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (bus.start) begin
               state_next = ST_FETCH;
               pc_next    = BOOT_PC;
               fifo_flush = 1'b1;
            end
         end
         ST_FETCH: begin
            if (bus.redirect) begin
               // Redirect beats everything, including a HALT being fetched.
               pc_next    = bus.redirect_pc;
               fifo_flush = 1'b1;
            end else if (!fifo_full || fifo_pop) begin
               fifo_push = 1'b1;
               pc_next   = pc_reg + 32'd1;
               if (is_halt(bus.inst))
                  state_next = ST_HALTED;
            end
         end
         ST_HALTED: begin
            if (bus.start) begin
               state_next = ST_FETCH;
               pc_next    = BOOT_PC;
               fifo_flush = 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
            pc_next    = BOOT_PC;
            fifo_flush = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a scoreboard of expected decode
// transfers; one line printed per transfer.
module tb_fetch_ctrl;
   import fetch_ctrl_pkg::*;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic clk;
   logic rst_n;

   logic        halt_en0;
   logic [31:0] halt_at0;

   exp_t q0[$];
   exp_t q1[$];

   int n_cmp;
   int n_fail;

   fetch_ctrl_if bus0 ();
   fetch_ctrl_if bus1 ();

   fetch_ctrl #(.BOOT_PC(32'd0), .FIFO_DEPTH(2)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   fetch_ctrl #(.BOOT_PC(32'hFFFF_FFFF), .FIFO_DEPTH(2)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   // Instruction memory image: HALT at one chosen address, ADD elsewhere.
   function automatic logic [31:0] mem_word(input logic [31:0] a,
                                            input logic hen,
                                            input logic [31:0] hat);
      if (hen && a == hat) return {OP_HALT, a[25:0]};
      return {OP_ADD, a[25:0]};
   endfunction

   assign bus0.inst = mem_word(bus0.pc, halt_en0, halt_at0);
   assign bus1.inst = mem_word(bus1.pc, 1'b0, 32'd0);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic exp0(input logic [31:0] p);
      exp_t e;
      e.pc   = p;
      e.inst = mem_word(p, halt_en0, halt_at0);
      q0.push_back(e);
   endtask

   task automatic exp1(input logic [31:0] p);
      exp_t e;
      e.pc   = p;
      e.inst = mem_word(p, 1'b0, 32'd0);
      q1.push_back(e);
   endtask

   // Compare any transfer that will occur at the coming edge with the scoreboard.
   task automatic check_xfer();
      exp_t e;
      if (bus0.out_valid === 1'b1 && bus0.out_ready === 1'b1) begin
         $display("xfer dut0 pc=%h inst=%h", bus0.out_pc, bus0.out_inst);
         n_cmp++;
         assert (q0.size() != 0) else begin
            n_fail++;
            $error("FAIL dut0_unexpected_xfer: observed pc %h expected no transfer", bus0.out_pc);
         end
         if (q0.size() != 0) begin
            e = q0.pop_front();
            chk("dut0_out_pc", {32'd0, bus0.out_pc}, {32'd0, e.pc});
            chk("dut0_out_inst", {32'd0, bus0.out_inst}, {32'd0, e.inst});
         end
      end
      if (bus1.out_valid === 1'b1 && bus1.out_ready === 1'b1) begin
         $display("xfer dut1 pc=%h inst=%h", bus1.out_pc, bus1.out_inst);
         n_cmp++;
         assert (q1.size() != 0) else begin
            n_fail++;
            $error("FAIL dut1_unexpected_xfer: observed pc %h expected no transfer", bus1.out_pc);
         end
         if (q1.size() != 0) begin
            e = q1.pop_front();
            chk("dut1_out_pc", {32'd0, bus1.out_pc}, {32'd0, e.pc});
            chk("dut1_out_inst", {32'd0, bus1.out_inst}, {32'd0, e.inst});
         end
      end
   endtask

   // One clock: check transfers mid-cycle, then return just after the edge.
   task automatic cyc();
      @(negedge clk);
      check_xfer();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cnt;
      n_cmp  = 0;
      n_fail = 0;
      halt_en0 = 1'b0;
      halt_at0 = 32'd0;
      rst_n = 1'b0;
      bus0.start = 1'b0; bus0.out_ready = 1'b0; bus0.redirect = 1'b0; bus0.redirect_pc = 32'd0;
      bus1.start = 1'b0; bus1.out_ready = 1'b0; bus1.redirect = 1'b0; bus1.redirect_pc = 32'd0;

      // Reset state.
      cyc(); cyc();
      chk("rst_out_valid", {63'd0, bus0.out_valid}, 64'd0);
      chk("rst_halted", {63'd0, bus0.halted}, 64'd0);
      chk("rst_pc", {32'd0, bus0.pc}, 64'd0);
      chk("rst_out_pc", {32'd0, bus0.out_pc}, 64'd0);
      chk("rst_out_inst", {32'd0, bus0.out_inst}, 64'd0);
      chk("rst_pc_boot_ffff", {32'd0, bus1.pc}, {32'd0, 32'hFFFF_FFFF});
      rst_n = 1'b1;
      cyc();

      // Straight-line run to HALT at pc 6 with decode always ready.
      halt_en0 = 1'b1;
      halt_at0 = 32'd6;
      bus0.out_ready = 1'b1;
      for (int i = 0; i <= 6; i++) exp0(i);
      bus0.start = 1'b1;
      cyc();
      bus0.start = 1'b0;
      chk("start_pc", {32'd0, bus0.pc}, 64'd0);
      chk("start_out_valid", {63'd0, bus0.out_valid}, 64'd0);
      cnt = 0;
      while (bus0.halted !== 1'b1 && cnt < 20) begin
         cyc();
         cnt++;
      end
      chk("halt_cycles", 64'(cnt), 64'd7);
      chk("halt_out_pc", {32'd0, bus0.out_pc}, 64'd6);
      chk("halt_pc", {32'd0, bus0.pc}, 64'd7);
      bus0.redirect = 1'b1;
      bus0.redirect_pc = 32'd5;
      cyc();
      bus0.redirect = 1'b0;
      cyc(); cyc();
      chk("halted_pc_frozen", {32'd0, bus0.pc}, 64'd7);
      chk("halted_stays", {63'd0, bus0.halted}, 64'd1);
      chk("halted_drained", {63'd0, bus0.out_valid}, 64'd0);
      chk("halt_sb_empty", 64'(q0.size()), 64'd0);

      // Back-pressure: restart from HALTED with decode stalled.
      halt_en0 = 1'b0;
      bus0.out_ready = 1'b0;
      bus0.start = 1'b1;
      cyc();
      bus0.start = 1'b0;
      chk("restart_halted", {63'd0, bus0.halted}, 64'd0);
      for (int i = 0; i < 5; i++) cyc();
      chk("stall_pc", {32'd0, bus0.pc}, 64'd2);
      chk("stall_out_valid", {63'd0, bus0.out_valid}, 64'd1);
      chk("stall_out_pc", {32'd0, bus0.out_pc}, 64'd0);
      chk("stall_out_inst", {32'd0, bus0.out_inst}, {32'd0, mem_word(32'd0, 1'b0, 32'd0)});
      for (int i = 0; i < 8; i++) exp0(i);
      bus0.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) cyc();
      bus0.out_ready = 1'b0;
      chk("release_sb_empty", 64'(q0.size()), 64'd0);

      // Redirect while entries 4,5 are buffered.
      bus0.redirect = 1'b1;
      bus0.redirect_pc = 32'd4;
      cyc();
      bus0.redirect = 1'b0;
      cyc(); cyc();
      chk("buf45_out_pc", {32'd0, bus0.out_pc}, 64'd4);
      chk("buf45_pc", {32'd0, bus0.pc}, 64'd6);
      bus0.redirect = 1'b1;
      bus0.redirect_pc = 32'd2;
      cyc();
      bus0.redirect = 1'b0;
      chk("redir_flush_valid", {63'd0, bus0.out_valid}, 64'd0);
      chk("redir_pc", {32'd0, bus0.pc}, 64'd2);
      exp0(2); exp0(3); exp0(4);
      bus0.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      chk("redir_sb_empty", 64'(q0.size()), 64'd0);

      // Redirect in the same cycle as a handshake: head 5 still transfers.
      exp0(5); exp0(9); exp0(10);
      bus0.redirect = 1'b1;
      bus0.redirect_pc = 32'd9;
      cyc();
      bus0.redirect = 1'b0;
      chk("redir_hs_flush_valid", {63'd0, bus0.out_valid}, 64'd0);
      cyc(); cyc(); cyc();
      bus0.out_ready = 1'b0;
      chk("redir_hs_sb_empty", 64'(q0.size()), 64'd0);

      // HALT fetched at pc 6 in the same cycle as a redirect to 2.
      halt_en0 = 1'b1;
      halt_at0 = 32'd6;
      bus0.redirect = 1'b1;
      bus0.redirect_pc = 32'd6;
      cyc();
      bus0.redirect_pc = 32'd2;
      cyc();
      bus0.redirect = 1'b0;
      chk("halt_vs_redir_halted", {63'd0, bus0.halted}, 64'd0);
      chk("halt_vs_redir_valid", {63'd0, bus0.out_valid}, 64'd0);
      chk("halt_vs_redir_pc", {32'd0, bus0.pc}, 64'd2);
      halt_en0 = 1'b0;
      exp0(2); exp0(3);
      bus0.out_ready = 1'b1;
      cyc(); cyc(); cyc();
      bus0.out_ready = 1'b0;
      chk("halt_vs_redir_sb_empty", 64'(q0.size()), 64'd0);
      chk("halt_vs_redir_still_run", {63'd0, bus0.halted}, 64'd0);

      // Reset with a full buffer; start and redirect asserted alongside.
      cyc(); cyc();
      chk("prerst_valid", {63'd0, bus0.out_valid}, 64'd1);
      rst_n = 1'b0;
      bus0.start = 1'b1;
      bus0.redirect = 1'b1;
      bus0.redirect_pc = 32'd3;
      cyc();
      rst_n = 1'b1;
      bus0.start = 1'b0;
      bus0.redirect = 1'b0;
      chk("midrst_valid", {63'd0, bus0.out_valid}, 64'd0);
      chk("midrst_out_pc", {32'd0, bus0.out_pc}, 64'd0);
      chk("midrst_out_inst", {32'd0, bus0.out_inst}, 64'd0);
      chk("midrst_pc", {32'd0, bus0.pc}, 64'd0);
      cyc(); cyc(); cyc();
      chk("idle_no_fetch_valid", {63'd0, bus0.out_valid}, 64'd0);
      chk("idle_no_fetch_pc", {32'd0, bus0.pc}, 64'd0);
      exp0(0); exp0(1);
      bus0.out_ready = 1'b1;
      bus0.start = 1'b1;
      cyc();
      bus0.start = 1'b0;
      cyc(); cyc(); cyc();
      bus0.out_ready = 1'b0;
      chk("resume_sb_empty", 64'(q0.size()), 64'd0);

      // pc wrap from 32'hFFFFFFFF on the second instance.
      exp1(32'hFFFF_FFFF); exp1(32'd0); exp1(32'd1);
      bus1.out_ready = 1'b1;
      bus1.start = 1'b1;
      cyc();
      bus1.start = 1'b0;
      chk("wrap_start_pc", {32'd0, bus1.pc}, {32'd0, 32'hFFFF_FFFF});
      cyc(); cyc(); cyc(); cyc();
      bus1.out_ready = 1'b0;
      chk("wrap_sb_empty", 64'(q1.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: BOOT_PC, 32'd0, PC loaded on start from IDLE or HALTED.
REQ-002 Parameter: FIFO_DEPTH, 2, fetch buffer entries (power of two, >=2).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: start  input  1  pulse; begins fetching at BOOT_PC from IDLE or HALTED.
REQ-006 Port: pc  output  32  word address driven to instruction memory.
REQ-007 Port: inst  input  `WIDTH  instruction word; combinational read of mem[pc], valid same cycle.
REQ-008 Port: out_valid  output  1  fetched instruction available to decode.
REQ-009 Port: out_ready  input  1  decode accepts; transfer when out_valid && out_ready.
REQ-010 Port: out_inst  output  `WIDTH  instruction at FIFO head.
REQ-011 Port: out_pc  output  32  address of out_inst.
REQ-012 Port: redirect  input  1  taken branch from execute; flush and refetch.
REQ-013 Port: redirect_pc  input  32  branch target, sampled when redirect=1.
REQ-014 Port: halted  output  1  high in HALTED state.

Function
REQ-015 States: IDLE, FETCH, HALTED; reset enters IDLE.
REQ-016 IDLE: no fetch; start -> FETCH, pc<=BOOT_PC; redirect ignored.
REQ-017 FETCH: each cycle FIFO not full (or popped this cycle), push {pc, inst} and pc<=pc+1.
REQ-018 FIFO full with no pop: no push, pc held (stall), no word lost or duplicated.
REQ-019 Push and pop same cycle on full FIFO: both occur, count unchanged.
REQ-020 Fetch latency: word at pc visible on out_inst one cycle after push cycle when FIFO was empty.
REQ-021 pc increments modulo 2^32; 32'hFFFFFFFF wraps to 32'd0.
REQ-022 Pushed word with opcode field (inst[`WIDTH-1 -: `OP_BITS]) == `HALT: word is pushed, state -> HALTED, no further pushes.
REQ-023 HALTED: FIFO keeps draining to decode; halted=1; pc frozen; redirect ignored; start -> FETCH at BOOT_PC with FIFO flushed.
REQ-024 redirect in FETCH: FIFO flushed (out_valid=0 next cycle), pc<=redirect_pc, no push that cycle.
REQ-025 redirect same cycle as HALT fetch: redirect wins, HALT word discarded, state stays FETCH.
REQ-026 redirect same cycle as out_ready handshake: head transfer completes, then flush.
REQ-027 out_valid = FIFO non-empty; out_inst/out_pc stable while out_valid && !out_ready.

Reset
REQ-028 rst_n=0 at a rising edge: state IDLE, pc=BOOT_PC, FIFO empty, out_valid=0, halted=0, regardless of activity.
REQ-029 Reset mid-fetch or mid-handshake discards all buffered words; outputs out_inst/out_pc reset to 0.
REQ-030 rst_n has priority over start and redirect in the same cycle.

Structure
REQ-031 `WIDTH, `OP_BITS, opcode values (`HALT, `BR, ...) and state encodings live in defines.vh.
REQ-032 Buffer implemented as sub-module fetch_fifo (parameterised depth/width, push/pop/flush, full/empty).
REQ-033 No combinational path from out_ready or redirect to pc.

Verification
REQ-034 Reset, start, mem = 6 non-HALT words then HALT, out_ready=1 -> out_pc 0..6 in order one per cycle, halted=1 after pc 6 pushed, pc stays 7.
REQ-035 out_ready=0 for 5 cycles after start -> exactly 2 entries buffered (pc 0,1), pc held at 2; release -> pc 0,1,2... with no gap or duplicate.
REQ-036 redirect with redirect_pc=32'd2 while entries 4,5 buffered -> next out_pc=2, entries 4,5 never transferred.
REQ-037 HALT fetched at pc 6 with redirect to 2 same cycle -> no HALT at output, halted=0, next out_pc=2.
REQ-038 BOOT_PC=32'hFFFFFFFF, start -> out_pc FFFFFFFF then 00000000.
REQ-039 rst_n=0 for one cycle with FIFO full and out_valid=1 -> next cycle out_valid=0, IDLE, start required to resume from BOOT_PC.
